// File: rtl/daq_trig_sequencer.sv
// Trigger-to-readout acquisition sequencer: delay, capture window, readout handshake.
// Optional readout watchdog enabled by defining TRIG_TIMEOUT_EN.
module daq_trig_sequencer #(
    parameter int DELAY_W     = 8,
    parameter int NSAMP_W     = 10,
    parameter int TAG_W       = 6,
    parameter int MISS_W      = 8,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               trig_in,
    input  logic [TAG_W-1:0]   pulse_ctr_in,
    input  logic               run,
    input  logic [DELAY_W-1:0] delay,
    input  logic [NSAMP_W-1:0] n_samples,
    input  logic               rd_done,
    output logic               trig_rdy,
    output logic               acq_en,
    output logic [NSAMP_W-1:0] sample_addr,
    output logic               rd_req,
    output logic [TAG_W-1:0]   tag,
    output logic [MISS_W-1:0]  miss_ctr,
    output logic               timeout_flag
);

    typedef enum logic [1:0] {IDLE, DELAY, ACQ, READOUT} state_t;

    state_t             state_q, state_d;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [NSAMP_W-1:0] last_q, last_d;
    logic [NSAMP_W-1:0] addr_d;
    logic [TAG_W-1:0]   tag_d;
    logic [MISS_W-1:0]  miss_d;
    logic               rdy_d, acq_d, req_d;
    logic               trig_ok;

    assign trig_ok = trig_in & run;

`ifdef TRIG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            tflag_d;
    logic            wd_exp;
    assign wd_exp = (wd_q == WD_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_flag = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        last_d  = last_q;
        addr_d  = sample_addr;
        tag_d   = tag;
        miss_d  = miss_ctr;
        rdy_d   = trig_rdy;
        acq_d   = acq_en;
        req_d   = rd_req;
`ifdef TRIG_TIMEOUT_EN
        wd_d    = wd_q;
        tflag_d = timeout_flag;
`endif
        if (trig_ok && state_q != IDLE && miss_ctr != {MISS_W{1'b1}})
            miss_d = miss_ctr + MISS_W'(1);

        unique case (state_q)
            IDLE: begin
                if (trig_ok) begin
                    tag_d  = pulse_ctr_in;
                    // n-1 also encodes the 2^NSAMP_W case when n_samples is 0
                    last_d = n_samples - NSAMP_W'(1);
                    rdy_d  = 1'b0;
`ifdef TRIG_TIMEOUT_EN
                    tflag_d = 1'b0;
`endif
                    if (delay == '0) begin
                        state_d = ACQ;
                        acq_d   = 1'b1;
                        addr_d  = '0;
                    end else begin
                        state_d = DELAY;
                        dcnt_d  = delay - DELAY_W'(1);
                    end
                end
            end
            DELAY: begin
                if (dcnt_q == '0) begin
                    state_d = ACQ;
                    acq_d   = 1'b1;
                    addr_d  = '0;
                end else begin
                    dcnt_d = dcnt_q - DELAY_W'(1);
                end
            end
            ACQ: begin
                if (sample_addr == last_q) begin
                    state_d = READOUT;
                    acq_d   = 1'b0;
                    addr_d  = '0;
                    req_d   = 1'b1;
`ifdef TRIG_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    addr_d = sample_addr + NSAMP_W'(1);
                end
            end
            READOUT: begin
`ifdef TRIG_TIMEOUT_EN
                wd_d = wd_q + WD_W'(1);
`endif
                if (rd_done) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    rdy_d   = 1'b1;
                end
`ifdef TRIG_TIMEOUT_EN
                else if (wd_exp) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    rdy_d   = 1'b1;
                    tflag_d = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (!run && state_q != IDLE) begin
            state_d = IDLE;
            acq_d   = 1'b0;
            req_d   = 1'b0;
            addr_d  = '0;
            rdy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            dcnt_q      <= '0;
            last_q      <= '0;
            sample_addr <= '0;
            tag         <= '0;
            miss_ctr    <= '0;
            trig_rdy    <= 1'b1;
            acq_en      <= 1'b0;
            rd_req      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            last_q      <= last_d;
            sample_addr <= addr_d;
            tag         <= tag_d;
            miss_ctr    <= miss_d;
            trig_rdy    <= rdy_d;
            acq_en      <= acq_d;
            rd_req      <= req_d;
        end
    end

`ifdef TRIG_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_q         <= '0;
            timeout_flag <= 1'b0;
        end else begin
            wd_q         <= wd_d;
            timeout_flag <= tflag_d;
        end
    end
`endif

endmodule
